// File: rtl/shift_sequencer.sv
// shift_sequencer: multi-pass controller around the 4-bit shifter unit.
// Latches an operand, select code and pass count, then recirculates the
// shifter output into the working register once per clock until the count
// runs out, finishing with a one-cycle done pulse.

// Combinational 4-bit shifter: pass, clear bit, zero, rotate.
module shifter4 (
    input  logic [3:0] d,
    input  logic [2:0] s,
    output logic [3:0] y
);
    // Select-code decode of the per-pass transfer.
    always_comb begin
        y = d;
        case (s)
            3'b001:  y = {d[3:1], 1'b0};
            3'b010:  y = {1'b0, d[2:0]};
            3'b011:  y = 4'b0000;
            3'b101:  y = {d[2], d[1], d[0], d[3]};
            3'b110:  y = {d[0], d[3], d[2], d[1]};
            default: y = d;
        endcase
    end
endmodule

module shift_sequencer #(
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [3:0]       din,
    input  logic [2:0]       op,
    input  logic [CNT_W-1:0] count,
    output logic [3:0]       y,
    output logic             busy,
    output logic             done
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [3:0]       work;
    logic [2:0]       op_q;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       sh_y;

    shifter4 u_shifter (
        .d (work),
        .s (op_q),
        .y (sh_y)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic; abort wins over the pass, last pass is cnt==1.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) state_nxt = (count == '0) ? DONE : RUN;
            end
            RUN: begin
                if (abort)                                state_nxt = IDLE;
                else if (cnt == {{(CNT_W-1){1'b0}}, 1'b1}) state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: load on accepted start, recirculate one pass per RUN cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            work <= 4'b0000;
            op_q <= 3'b000;
            cnt  <= '0;
        end else begin
            if (state == IDLE && start) begin
                work <= din;
                op_q <= op;
                cnt  <= count;
            end else if (state == RUN && !abort) begin
                work <= sh_y;
                if (cnt != '0) cnt <= cnt - 1'b1;
            end
        end
    end

    assign y    = work;
    assign busy = (state == RUN);
    assign done = (state == DONE);
endmodule

// File: tb/tb_shift_sequencer.sv
// Bench for shift_sequencer: directed cases plus randomized transactions
// checked against a transaction-level reference model.
module tb_shift_sequencer;
    localparam int CNT_W = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             start, abort;
    logic [3:0]       din;
    logic [2:0]       op;
    logic [CNT_W-1:0] count;
    logic [3:0]       y;
    logic             busy, done;

    int nvec = 0;
    int nerr = 0;

    shift_sequencer #(.CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .abort (abort),
        .din   (din),
        .op    (op),
        .count (count),
        .y     (y),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] act, input logic [7:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Reference pass transfer, written from the table with arithmetic.
    function automatic logic [3:0] pass(input logic [2:0] o, input logic [3:0] v);
        int x;
        x = v;
        case (o)
            3'd1:    x = x & 14;
            3'd2:    x = x & 7;
            3'd3:    x = 0;
            3'd5:    x = ((x * 2) + (x / 8)) % 16;
            3'd6:    x = (x / 2) + ((x % 2) * 8);
            default: x = v;
        endcase
        return 4'(x);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One transaction. ab=k (1..n) raises abort at edge Ek; ab=0 means none.
    // Inputs are scrambled after acceptance and start is toggled while busy.
    task automatic run_seq(input logic [3:0] d, input logic [2:0] o,
                           input int n, input int ab);
        logic [3:0] exp;
        start = 1'b1; din = d; op = o; count = CNT_W'(n); abort = 1'b0;
        step();
        exp   = d;
        din   = 4'($urandom); op = 3'($urandom); count = CNT_W'($urandom);
        start = 1'($urandom);
        if (n == 0) begin
            start = 1'b0;
            abort = 1'($urandom);
            chk("zc_done", {7'b0, done}, 8'd1);
            chk("zc_busy", {7'b0, busy}, 8'd0);
            chk("zc_y",    {4'b0, y},    {4'b0, d});
            step();
            abort = 1'b0;
            chk("zc_idle_done", {7'b0, done}, 8'd0);
            chk("zc_idle_y",    {4'b0, y},    {4'b0, d});
            return;
        end
        for (int k = 1; k <= n; k++) begin
            chk("run_busy", {7'b0, busy}, 8'd1);
            chk("run_done", {7'b0, done}, 8'd0);
            chk("run_y",    {4'b0, y},    {4'b0, exp});
            if (k == ab) begin
                abort = 1'b1;
                start = 1'b0;
                step();
                abort = 1'b0;
                chk("ab_busy", {7'b0, busy}, 8'd0);
                chk("ab_done", {7'b0, done}, 8'd0);
                chk("ab_y",    {4'b0, y},    {4'b0, exp});
                step();
                chk("ab_hold_done", {7'b0, done}, 8'd0);
                chk("ab_hold_y",    {4'b0, y},    {4'b0, exp});
                return;
            end
            if (k == n) start = 1'b0;
            step();
            exp = pass(o, exp);
            if (k < n) start = 1'($urandom);
        end
        abort = 1'($urandom);
        chk("fin_done", {7'b0, done}, 8'd1);
        chk("fin_busy", {7'b0, busy}, 8'd0);
        chk("fin_y",    {4'b0, y},    {4'b0, exp});
        step();
        abort = 1'b0;
        chk("post_done", {7'b0, done}, 8'd0);
        chk("post_busy", {7'b0, busy}, 8'd0);
        chk("post_y",    {4'b0, y},    {4'b0, exp});
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        din = 4'hA; op = 3'd5; count = 3'd3;
        #12;
        chk("rst_y",    {4'b0, y},    8'd0);
        chk("rst_busy", {7'b0, busy}, 8'd0);
        chk("rst_done", {7'b0, done}, 8'd0);
        rst = 1'b0;
        step();

        // Directed cases.
        run_seq(4'b1011, 3'b101, 2, 0);
        run_seq(4'b0001, 3'b110, 4, 0);
        run_seq(4'b1111, 3'b011, 3, 0);
        run_seq(4'b1010, 3'b000, 0, 0);
        run_seq(4'b0001, 3'b110, 7, 3);
        run_seq(4'b0110, 3'b101, 1, 0);
        run_seq(4'b1101, 3'b001, 7, 0);
        run_seq(4'b1101, 3'b010, 2, 1);

        // Asynchronous reset between E2 and E3 of a five-pass run.
        start = 1'b1; din = 4'b1001; op = 3'b101; count = 3'd5;
        step();
        start = 1'b0;
        step(); step();
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_y",    {4'b0, y},    8'd0);
        chk("mid_rst_busy", {7'b0, busy}, 8'd0);
        chk("mid_rst_done", {7'b0, done}, 8'd0);
        step();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("after_rst_done", {7'b0, done}, 8'd0);
            chk("after_rst_y",    {4'b0, y},    8'd0);
        end
        run_seq(4'b0011, 3'b110, 3, 0);

        // Randomized transactions.
        for (int t = 0; t < 300; t++) begin
            int n, ab;
            n  = $urandom_range(0, 7);
            ab = ($urandom_range(0, 3) == 0 && n > 0) ? $urandom_range(1, n) : 0;
            run_seq(4'($urandom), 3'($urandom), n, ab);
            if ($urandom_range(0, 1) == 1) step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/shift_sequencer.md
# shift_sequencer

Multi-pass controller for the 4-bit shifter unit. It latches an operand, a shifter select code and a pass count, then feeds the shifter's output back to its input once per clock until the count is exhausted. It signals completion with a one-cycle `done` pulse. It sits between the processing-unit control logic and the combinational shifter, adding an N-position shift/rotate capability to the datapath.

## Interface
- `CNT_W`, default 3: width of the pass-count input; allows up to 2^CNT_W−1 passes.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: request a sequence; sampled only in IDLE.
- `abort` in 1: cancel a running sequence; sampled only in RUN.
- `din` in 4: operand, latched on an accepted `start`.
- `op` in 3: shifter select code, latched on an accepted `start`.
- `count` in CNT_W: number of shifter passes, latched on an accepted `start`.
- `y` out 4: working register, driven continuously.
- `busy` out 1: high while in RUN.
- `done` out 1: one-cycle completion pulse, high in DONE.

## Operation
- Instantiates the existing shifter unit. Its D input is the working register, its S input is the latched `op`, and its Y output is the next register value.
- Per-pass transfer, as implemented by the shifter:
  - 000: pass through.
  - 001: clear bit 0.
  - 010: clear bit 3.
  - 011: all zero.
  - 100: pass through.
  - 101: rotate left, {D2,D1,D0,D3}.
  - 110: rotate right, {D0,D3,D2,D1}.
  - 111: pass through.
- States and transitions:
  - IDLE → RUN on `start` with `count`≠0. Load `din` into the register; latch `op` and `count` into the remaining-pass counter.
  - IDLE → DONE on `start` with `count`=0. Load `din`; no passes are applied.
  - RUN, `abort`=0: register ← shifter output; counter decrements. When the counter is 1 at the edge (last pass), go to DONE; otherwise stay in RUN.
  - RUN, `abort`=1: go to IDLE. No pass is applied on that edge, the register keeps its partial value, and no `done` is produced. `abort` has priority over the pass.
  - DONE → IDLE unconditionally.
- `start` in RUN or DONE is ignored; there is no queuing. `abort` in IDLE or DONE is ignored.
- Changes to `din`, `op` or `count` after acceptance have no effect on the running sequence.
- `y` holds its final or aborted value until the next accepted `start` or reset.
- Reset (any time, including mid-RUN): state IDLE, `y`=0000, counter 0, latched op 000, `busy`=0, `done`=0. No `done` pulse follows reset.

## Timing
- Edge E0 samples `start` in IDLE. For `count`=N≥1:
  - `busy` is high from after E0 through E(N−1).
  - Passes are applied at edges E1..EN.
  - `done` is high for exactly the cycle between EN and E(N+1); `y` is final in that cycle.
  - State returns to IDLE at E(N+1).
  - The earliest next `start` is sampled at E(N+1).
- For `count`=0: `done` is high for the cycle after E0 with `y`=`din`.
- Outputs are registered or pure state decodes; there is no combinational path from inputs to `busy`/`done`/`y`.
- Maximum count 2^CNT_W−1 (7 by default); the counter never wraps below zero.

## Test plan
- ROL: `din`=1011, `op`=101, `count`=2 → `y`=0111 after E1, 1110 after E2; `done` for one cycle after E2; `busy` high for two cycles.
- ROR full circle: `din`=0001, `op`=110, `count`=4 → `y` sequence 1000, 0100, 0010, 0001; single `done` pulse; `start` asserted while busy is ignored.
- Zero op and zero count:
  - `din`=1111, `op`=011, `count`=3 → `y`=0000, `done` after E3.
  - `din`=1010, `count`=0 → `done` in the cycle after E0, `y`=1010, `busy` never high.
- Abort: `din`=0001, `op`=110, `count`=7, `abort` high at E3 → `y`=0100 (passes at E1, E2 only), state IDLE after E3, no `done`; a new `start` at E4 is accepted.
- Reset mid-RUN: assert `rst` asynchronously between E2 and E3 of a `count`=5 run → `y`=0000, `busy`=0, `done`=0 immediately; no `done` after release; the next `start` behaves normally.
